mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Initiator-side controller for the single-port data memory. It accepts byte-addressed load/store requests from the CPU datapath over a valid/ready handshake.
- It drives the memory's doubleword-indexed read/write port and sequences read-modify-write for sub-doubleword stores.
- It returns aligned, sign- or zero-extended load data with a one-cycle response pulse.
- It sits between the pipeline MEM stage and the memory array.

Parameters:
- n, 64: data and address width in bits; memory word = n bits = 8 bytes.
- log2Size, 10: log2 of memory depth in words. Valid byte addresses are 0 .. (2^log2Size)*8-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  controller can accept a request.
- reqWr  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- reqSigned  in  1  sign-extend load result (ignored for stores and doubleword loads).
- reqAddr  in  n  byte address.
- reqWData  in  n  store data, right-justified.
- respValid  out  1  one-cycle completion pulse.
- respErr  out  1  qualifies respValid: misaligned or out-of-range request, no memory access performed.
- respRData  out  n  load result; 0 for stores and errors.
- memAddress  out  n  word index to memory.
- memDataIn  out  n  write data to memory.
- memRead  out  1  memory read enable.
- memWr  out  1  memory write enable.
- memDataOut  in  n  combinational read data from memory; high-Z when memRead=0.

Behaviour:
- Reset (async, rst_n=0): state IDLE. reqReady=1, respValid=0, respErr=0, respRData=0, memRead=0, memWr=0, memAddress=0, memDataIn=0.
  - Reset mid-operation drops the pending request.
  - No memWr pulse may occur after rst_n falls.
- Request acceptance:
  - reqReady=1 only in IDLE.
  - A request is accepted at a rising edge with reqValid&reqReady. All req* fields are latched then; later changes are ignored.
- Address decode:
  - byte offset = addr[2:0]
  - index = addr[log2Size+2:3]
  - memAddress = index zero-extended to n bits
- Errors, checked at acceptance:
  - Misaligned: half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0.
  - Out of range: any addr bit above log2Size+2 is set.
  - On error, go directly to RESP with respErr=1. No memRead or memWr is asserted.
- State IDLE: outputs to memory deasserted.
  - Accepted load or sub-dword store -> RD.
  - Accepted dword store -> WR.
  - Error -> RESP.
- State RD (one cycle): memRead=1, memAddress=index.
  - memDataOut is captured into the word buffer at the closing edge.
  - Load -> RESP. Store -> WR.
- State WR (one cycle): memWr=1, memAddress=index, memDataIn=merged word.
  - Dword store: merged word = reqWData.
  - Sub-dword store: buffer with lanes [offset*8 +: size bytes] replaced by low bytes of reqWData. Other bytes are unchanged.
  - Memory writes at the closing edge. Next state RESP.
- State RESP (one cycle): respValid=1, reqReady=0.
  - Load: respRData = buffer lanes selected by offset/size. Sign-extended if reqSigned and size<dword, otherwise zero-extended.
  - Next state IDLE; a new request is accepted on the following edge.
- Latency, in cycles from the accept edge to respValid high:
  - load: 2 (RD, RESP)
  - dword store: 2 (WR, RESP)
  - sub-dword store: 3 (RD, WR, RESP)
  - error: 1
  - Throughput is one request per (latency+1) cycles.
- memRead and memWr are never both 1. memRead is 0 outside RD, so memDataOut is only sampled in RD.
- No response backpressure: respValid is a pulse, and the consumer must take it.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - state encoding IDLE/RD/WR/RESP
  - byte-lane width constant 8
- Sub-module mem_lane_align (combinational), with two functions:
  - extract and extend: buffer, offset, size, signed -> load data
  - merge: buffer, wdata, offset, size -> merged word
- The FSM and registers stay in mem_master.

Test Plan:
- Dword store then load: store addr=0x18, data=0x0123456789ABCDEF.
  -> memWr=1 one cycle with memAddress=3, respValid after 2 cycles.
  -> load same addr returns 0x0123456789ABCDEF, respErr=0.
- Byte RMW: word 3 = 0x0123456789ABCDEF; store byte 0xAA at addr=0x1A.
  -> RD then WR with memDataIn=0x0123456789AACDEF.
  -> unsigned byte load at 0x1A returns 0xAA.
  -> signed byte load at 0x1A returns 0xFFFFFFFFFFFFFFAA.
- Signed half load at 0x1E returns 0x0000000000000123. Word load at 0x1C with reqSigned=1 returns 0x0000000001234567.
- Errors: half load at 0x1B, and any access at 0x2000 (log2Size=10).
  -> respValid&respErr after 1 cycle, respRData=0, memRead=memWr=0 throughout.
- Handshake: hold reqValid=1 with back-to-back requests.
  -> reqReady low from accept through RESP; second request accepted only the edge after RESP; req* changes during the busy period have no effect.
- Reset mid-RMW: assert rst_n=0 during RD of a byte store.
  -> outputs return to reset values immediately, no memWr pulse, and the target word is unchanged on a subsequent load.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the data-memory master
package mem_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // Natural alignment: the low log2(bytes) address bits must be clear.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
        logic r;
        case (size)
            SZ_H:    r = offset[0];
            SZ_W:    r = |offset[1:0];
            SZ_D:    r = |offset[2:0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane extract/extend for loads and merge for stores
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] i_word,
    input  logic [N-1:0] i_wdata,
    input  logic [2:0]   i_offset,
    input  logic [1:0]   i_size,
    input  logic         i_signed,
    output logic [N-1:0] o_rdata,
    output logic [N-1:0] o_merged
);

    function automatic logic [N-1:0] extract(input logic [N-1:0] word, input logic [2:0] off,
                                             input logic [1:0] size, input logic sgn);
        logic [N-1:0] sh;
        logic [N-1:0] r;
        sh = word >> (int'(off) * LANE_W);
        case (size)
            SZ_B:    r = {{(N-8){sgn & sh[7]}}, sh[7:0]};
            SZ_H:    r = {{(N-16){sgn & sh[15]}}, sh[15:0]};
            SZ_W:    r = {{(N-32){sgn & sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    function automatic logic [N-1:0] merge(input logic [N-1:0] word, input logic [N-1:0] wdata,
                                           input logic [2:0] off, input logic [1:0] size);
        logic [N-1:0] mask;
        case (size)
            SZ_B:    mask = {{(N-8){1'b0}}, {8{1'b1}}};
            SZ_H:    mask = {{(N-16){1'b0}}, {16{1'b1}}};
            SZ_W:    mask = {{(N-32){1'b0}}, {32{1'b1}}};
            default: mask = {N{1'b1}};
        endcase
        mask = mask << (int'(off) * LANE_W);
        return (word & ~mask) | ((wdata << (int'(off) * LANE_W)) & mask);
    endfunction

    assign o_rdata  = extract(i_word, i_offset, i_size, i_signed);
    assign o_merged = merge(i_word, i_wdata, i_offset, i_size);

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - load/store initiator with read-modify-write for sub-doubleword stores
module mem_master
    import mem_pkg::*;
#(
    parameter int n        = 64,
    parameter int log2Size = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reqValid,
    output logic         reqReady,
    input  logic         reqWr,
    input  logic [1:0]   reqSize,
    input  logic         reqSigned,
    input  logic [n-1:0] reqAddr,
    input  logic [n-1:0] reqWData,
    output logic         respValid,
    output logic         respErr,
    output logic [n-1:0] respRData,
    output logic [n-1:0] memAddress,
    output logic [n-1:0] memDataIn,
    output logic         memRead,
    output logic         memWr,
    input  logic [n-1:0] memDataOut
);

    state_e         r_state;
    logic           r_wr;
    logic [1:0]     r_size;
    logic           r_signed;
    logic [2:0]     r_offset;
    logic [n-1:0]   r_wdata;
    logic           r_req_ready;
    logic           r_resp_valid;
    logic           r_resp_err;
    logic [n-1:0]   r_resp_rdata;
    logic [n-1:0]   r_mem_addr;
    logic [n-1:0]   r_mem_data_in;
    logic           r_mem_read;
    logic           r_mem_wr;

    logic [log2Size-1:0] w_index;
    logic                w_oor;
    logic                w_err;
    logic [n-1:0]        w_rdata;
    logic [n-1:0]        w_merged;

    assign w_index = reqAddr[log2Size+2:3];
    assign w_oor   = |reqAddr[n-1:log2Size+3];
    assign w_err   = w_oor | misaligned(reqSize, reqAddr[2:0]);

    // Fed straight from memDataOut: the RD-cycle read is folded into the next registered output.
    mem_lane_align #(.N(n)) u_align (
        .i_word   (memDataOut),
        .i_wdata  (r_wdata),
        .i_offset (r_offset),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_rdata  (w_rdata),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_wr          <= 1'b0;
            r_size        <= SZ_B;
            r_signed      <= 1'b0;
            r_offset      <= '0;
            r_wdata       <= '0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= '0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_mem_read    <= 1'b0;
            r_mem_wr      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (reqValid && r_req_ready) begin
                        r_wr        <= reqWr;
                        r_size      <= reqSize;
                        r_signed    <= reqSigned;
                        r_offset    <= reqAddr[2:0];
                        r_wdata     <= reqWData;
                        r_req_ready <= 1'b0;
                        if (w_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (reqWr && reqSize == SZ_D) begin
                            r_state       <= WR;
                            r_mem_wr      <= 1'b1;
                            r_mem_addr    <= {{(n-log2Size){1'b0}}, w_index};
                            r_mem_data_in <= reqWData;
                        end else begin
                            r_state    <= RD;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= {{(n-log2Size){1'b0}}, w_index};
                        end
                    end
                end
                RD: begin
                    r_mem_read <= 1'b0;
                    if (r_wr) begin
                        r_state       <= WR;
                        r_mem_wr      <= 1'b1;
                        r_mem_data_in <= w_merged;
                    end else begin
                        r_state      <= RESP;
                        r_mem_addr   <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_rdata;
                    end
                end
                WR: begin
                    r_state       <= RESP;
                    r_mem_wr      <= 1'b0;
                    r_mem_addr    <= '0;
                    r_mem_data_in <= '0;
                    r_resp_valid  <= 1'b1;
                    r_resp_rdata  <= '0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign reqReady   = r_req_ready;
    assign respValid  = r_resp_valid;
    assign respErr    = r_resp_err;
    assign respRData  = r_resp_rdata;
    assign memAddress = r_mem_addr;
    assign memDataIn  = r_mem_data_in;
    assign memRead    = r_mem_read;
    assign memWr      = r_mem_wr;

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - scoreboard bench for mem_master against a byte-array reference model
module tb_mem_master;

    localparam int N     = 64;
    localparam int L2    = 10;
    localparam int WORDS = 1 << L2;
    localparam int BYTES = WORDS * 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         reqValid = 1'b0;
    logic         reqReady;
    logic         reqWr = 1'b0;
    logic [1:0]   reqSize = 2'b00;
    logic         reqSigned = 1'b0;
    logic [N-1:0] reqAddr = '0;
    logic [N-1:0] reqWData = '0;
    logic         respValid;
    logic         respErr;
    logic [N-1:0] respRData;
    logic [N-1:0] memAddress;
    logic [N-1:0] memDataIn;
    logic         memRead;
    logic         memWr;
    logic [N-1:0] memDataOut;

    mem_master #(.n(N), .log2Size(L2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqWr      (reqWr),
        .reqSize    (reqSize),
        .reqSigned  (reqSigned),
        .reqAddr    (reqAddr),
        .reqWData   (reqWData),
        .respValid  (respValid),
        .respErr    (respErr),
        .respRData  (respRData),
        .memAddress (memAddress),
        .memDataIn  (memDataIn),
        .memRead    (memRead),
        .memWr      (memWr),
        .memDataOut (memDataOut)
    );

    always #5 clk = ~clk;

    logic [N-1:0] mem [WORDS];
    logic [7:0]   ref_mem [BYTES];

    assign memDataOut = memRead ? mem[memAddress[L2-1:0]] : '0;
    always @(posedge clk) if (memWr) mem[memAddress[L2-1:0]] <= memDataIn;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] rd_q[$];
    logic [63:0] wa_q[$];
    logic [63:0] wd_q[$];
    int          acc_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            exp_t e;
            int   a;
            chk("req_ready", {63'd0, reqReady}, {63'd0, acc_q.size() == 0});
            chk("rd_wr_exclusive", {63'd0, memRead & memWr}, 64'd0);
            if (memRead) begin
                if (rd_q.size() == 0) chk("unexpected_memRead", {63'd0, memRead}, 64'd0);
                else chk("rd_addr", memAddress, rd_q.pop_front());
            end
            if (memWr) begin
                if (wa_q.size() == 0) chk("unexpected_memWr", {63'd0, memWr}, 64'd0);
                else begin
                    chk("wr_addr", memAddress, wa_q.pop_front());
                    chk("wr_data", memDataIn, wd_q.pop_front());
                end
            end
            if (respValid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0)
                    chk("unexpected_resp", {63'd0, respValid}, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("resp_err", {63'd0, respErr}, {63'd0, e.err});
                    chk("resp_rdata", respRData, e.rdata);
                    chk("resp_latency", 64'(cyc - a), 64'(e.lat));
                end
            end
            if (reqValid && reqReady) acc_q.push_back(cyc);
        end
    end

    // Reference model: plain byte-array semantics of a load/store.
    task automatic model(input bit wr, input logic [1:0] sz, input bit sg, input logic [63:0] addr,
                         input logic [63:0] wd, input bit has_exp, input logic [63:0] exp_rd);
        int          nb;
        int          base;
        logic [63:0] v;
        exp_t        e;
        nb = 1 << sz;
        if ((addr % nb) != 0 || addr >= 64'(BYTES)) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 1;
        end else if (wr) begin
            base = int'(addr) & ~7;
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
            v = '0;
            for (int i = 0; i < 8; i++) v |= 64'(ref_mem[base + i]) << (8 * i);
            if (sz != 2'b11) rd_q.push_back(addr >> 3);
            wa_q.push_back(addr >> 3);
            wd_q.push_back(v);
            e.err = 1'b0; e.rdata = '0; e.lat = (sz == 2'b11) ? 2 : 3;
        end else begin
            rd_q.push_back(addr >> 3);
            v = '0;
            for (int i = 0; i < nb; i++) v |= 64'(ref_mem[int'(addr) + i]) << (8 * i);
            if (sg && sz != 2'b11 && v[8*nb-1]) v |= ~64'd0 << (8 * nb);
            e.err = 1'b0; e.rdata = has_exp ? exp_rd : v; e.lat = 2;
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input bit wr, input logic [1:0] sz, input bit sg, input logic [63:0] addr,
                         input logic [63:0] wd, input bit has_exp = 1'b0, input logic [63:0] exp_rd = '0);
        bit got;
        model(wr, sz, sg, addr, wd, has_exp, exp_rd);
        reqValid = 1'b1; reqWr = wr; reqSize = sz; reqSigned = sg; reqAddr = addr; reqWData = wd;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = reqReady;
        end
        if (!got) chk("accept_timeout", {63'd0, reqReady}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        reqValid = 1'b0;
        reqWr = $urandom; reqSize = 2'($urandom); reqAddr = {$urandom, $urandom}; reqWData = {$urandom, $urandom};
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        reqValid = 1'b0;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [63:0] addr;
        for (int w = 0; w < WORDS; w++) begin
            mem[w] = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) ref_mem[w*8 + b] = mem[w][8*b +: 8];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reqReady", {63'd0, reqReady}, 64'd1);
        chk("rst_respValid", {63'd0, respValid}, 64'd0);
        chk("rst_respErr", {63'd0, respErr}, 64'd0);
        chk("rst_respRData", respRData, 64'd0);
        chk("rst_memRead", {63'd0, memRead}, 64'd0);
        chk("rst_memWr", {63'd0, memWr}, 64'd0);
        chk("rst_memAddress", memAddress, 64'd0);
        chk("rst_memDataIn", memDataIn, 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        issue(1, 2'b11, 0, 64'h18, 64'h0123456789ABCDEF);
        issue(0, 2'b11, 0, 64'h18, 64'h0, 1, 64'h0123456789ABCDEF);
        issue(1, 2'b00, 0, 64'h1A, 64'hAA);
        issue(0, 2'b00, 0, 64'h1A, 64'h0, 1, 64'hAA);
        issue(0, 2'b00, 1, 64'h1A, 64'h0, 1, 64'hFFFFFFFFFFFFFFAA);
        issue(0, 2'b01, 1, 64'h1E, 64'h0, 1, 64'h0123);
        issue(0, 2'b10, 1, 64'h1C, 64'h0, 1, 64'h01234567);
        issue(0, 2'b11, 0, 64'h18, 64'h0, 1, 64'h0123456789AACDEF);
        issue(0, 2'b01, 0, 64'h1B, 64'h0);
        issue(1, 2'b10, 0, 64'h2000, 64'h12345678);
        issue(0, 2'b00, 0, 64'h2000, 64'h0);
        issue(1, 2'b11, 0, 64'h1C, 64'h55);
        issue(0, 2'b11, 0, 64'h18, 64'h0, 1, 64'h0123456789AACDEF);
        issue(1, 2'b11, 0, 64'h1FF8, 64'hDEADBEEFCAFEF00D);
        issue(0, 2'b10, 1, 64'h1FFC, 64'h0, 1, 64'hFFFFFFFFDEADBEEF);
        idle(3);

        for (int t = 0; t < 400; t++) begin
            sz = 2'($urandom);
            if ($urandom_range(0, 15) == 0) addr = {$urandom, $urandom} >> $urandom_range(0, 50);
            else addr = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr &= ~((64'd1 << sz) - 1);
            issue($urandom_range(0, 1), sz, $urandom_range(0, 1), addr, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        drain();

        mon_en = 1'b0;
        rd_q.delete(); wa_q.delete(); wd_q.delete(); acc_q.delete(); exp_q.delete();
        reqValid = 1'b1; reqWr = 1'b1; reqSize = 2'b00; reqSigned = 1'b0; reqAddr = 64'h1A; reqWData = 64'h55;
        @(negedge clk);
        chk("rst_test_ready", {63'd0, reqReady}, 64'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(negedge clk);
        chk("rst_test_in_rd", {63'd0, memRead}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_memRead", {63'd0, memRead}, 64'd0);
        chk("mid_rst_memWr", {63'd0, memWr}, 64'd0);
        chk("mid_rst_reqReady", {63'd0, reqReady}, 64'd1);
        chk("mid_rst_respValid", {63'd0, respValid}, 64'd0);
        chk("mid_rst_memAddress", memAddress, 64'd0);
        chk("mid_rst_memDataIn", memDataIn, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_wr", {63'd0, memWr}, 64'd0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        issue(0, 2'b11, 0, 64'h18, 64'h0);
        issue(0, 2'b00, 0, 64'h1A, 64'h0);
        drain();

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("wr_q_empty", 64'(wa_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
